// File: rtl/add16_share_sched.sv
// Round-robin scheduler sharing one external 16-bit adder; optional error monitor under ADD16_ERRMON_EN.
// Latency: two cycles from grant to res_valid; one operation per cycle while res_ready=1.
// Backpressure: res_ready=0 holds stage 2, then stage 1; grants stop while both stages are full.
module add16_share_sched #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [16*N_REQ-1:0]   req_b,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    input  logic [16:0]           add_o,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [16:0]           res_sum,
    output logic [ID_W-1:0]       res_id
`ifdef ADD16_ERRMON_EN
    ,
    input  logic                  err_clr,
    output logic [16:0]           err_max,
    output logic [31:0]           err_cnt
`endif
);

    localparam logic [ID_W:0]   N_REQ_EXT = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(N_REQ - 1);

    logic            s1_v;
    logic [ID_W-1:0] s1_id;
    logic            s2_v;
    logic [ID_W-1:0] rr_ptr;
    logic            s1_free;
    logic            s2_free;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;

    assign s2_free   = !s2_v || res_ready;
    assign s1_free   = !s1_v || s2_free;
    assign res_valid = s2_v;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= N_REQ_EXT) begin
                cand = cand - N_REQ_EXT;
            end
            if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
        if (rst || !s1_free) begin
            grant_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_id   <= '0;
            s2_v    <= 1'b0;
            rr_ptr  <= '0;
            add_a   <= '0;
            add_b   <= '0;
            res_sum <= '0;
            res_id  <= '0;
        end else begin
            // Operands hold when idle so the shared adder inputs do not toggle.
            if (s1_free) begin
                if (grant_vld) begin
                    add_a  <= req_a[16*grant_idx +: 16];
                    add_b  <= req_b[16*grant_idx +: 16];
                    s1_id  <= grant_idx;
                    s1_v   <= 1'b1;
                    rr_ptr <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                end else begin
                    s1_v <= 1'b0;
                end
            end
            if (s1_v && s2_free) begin
                res_sum <= add_o;
                res_id  <= s1_id;
                s2_v    <= 1'b1;
            end else if (res_ready && s2_v) begin
                s2_v <= 1'b0;
            end
        end
    end

`ifdef ADD16_ERRMON_EN
    logic [16:0] exact_sum;
    logic [16:0] err_abs;

    assign exact_sum = {1'b0, add_a} + {1'b0, add_b};
    assign err_abs   = (exact_sum >= add_o) ? exact_sum - add_o : add_o - exact_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_max <= '0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err_max <= '0;
            err_cnt <= '0;
        end else if (s1_v && s2_free) begin
            if (err_abs > err_max) begin
                err_max <= err_abs;
            end
            if (err_abs != '0 && err_cnt != 32'hFFFF_FFFF) begin
                err_cnt <= err_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
